// File: rtl/wbu_param.sv
// Writeback unit: GPR file, small CSR file, retire handshake with ecall trap,
// ebreak halt, write-first read bypass and a pending-write scoreboard for decode.
module wbu_param #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NCSR    = 4,
    parameter int CW      = 2,
    parameter int ARG_REG = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rd,
    input  logic            reg_en,
    input  logic [XLEN-1:0] wd,
    input  logic [CW-1:0]   csr_rd,
    input  logic            csreg_en,
    input  logic [XLEN-1:0] csr_wd,
    input  logic            ecall,
    input  logic            ebreak_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [CW-1:0]   csr_rs,
    output logic [XLEN-1:0] rsa,
    output logic [XLEN-1:0] rsb,
    output logic [XLEN-1:0] csra,
    input  logic            mark_valid,
    input  logic [4:0]      mark_rd,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            ebreak_o,
    output logic [63:0]     retire_cnt,
    output logic [2:0]      state_o
);
    localparam int MCAUSE  = 0;
    localparam int MEPC    = 1;
    localparam int MSTATUS = 2;

    typedef enum logic [1:0] {RUN, TRAP, HALT} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] gpr [1:NREG-1];
    logic [XLEN-1:0] csr [NCSR];
    logic [NREG-1:1] busy;
    logic            acc, gpr_we, csr_we;

    assign in_ready = (state == RUN);
    assign acc      = in_valid & in_ready;
    assign gpr_we   = acc & reg_en & (rd != 5'd0) & (int'(rd) < NREG);
    assign csr_we   = acc & csreg_en & (int'(csr_rd) < NCSR);
    assign ebreak_o = (state == HALT);
    assign state_o  = acc ? {csreg_en, reg_en, 1'b1} : 3'b000;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_nx = state;
        case (state)
            RUN: begin
                if (acc && ebreak_i)   state_nx = HALT;
                else if (acc && ecall) state_nx = TRAP;
            end
            TRAP:    state_nx = RUN;
            HALT:    state_nx = HALT;
            default: state_nx = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        // NOTE: the register files are cleared on reset, so they map to flops, not RAM macros.
        if (!rst) begin
            for (int i = 1; i < NREG; i++) gpr[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                if (gpr_we && int'(rd) == i) gpr[i] <= wd;
        end
    end

    // Later assignments in this block override earlier ones: ecall beats csreg_en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCSR; i++) csr[i] <= '0;
        end else begin
            for (int i = 0; i < NCSR; i++)
                if (csr_we && int'(csr_rd) == i) csr[i] <= csr_wd;
            if (state == TRAP) begin
                csr[MSTATUS][7] <= csr[MSTATUS][3];
                csr[MSTATUS][3] <= 1'b0;
            end
            if (acc && ecall) begin
                csr[MCAUSE] <= gpr[ARG_REG];
                csr[MEPC]   <= pc_i;
            end
        end
    end

    // Scoreboard: an issue mark wins over a same-cycle retire clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (mark_valid && int'(mark_rd) == i)  busy[i] <= 1'b1;
                else if (gpr_we && int'(rd) == i)      busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)     retire_cnt <= '0;
        else if (acc) retire_cnt <= retire_cnt + 64'd1;
    end

    always_comb begin
        rsa      = '0;
        rsb      = '0;
        csra     = '0;
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (int'(rs1) == i) begin
                rsa      = gpr[i];
                busy_rs1 = busy[i] & ~(gpr_we & (rd == rs1) & ~(mark_valid & (mark_rd == rs1)));
            end
            if (int'(rs2) == i) begin
                rsb      = gpr[i];
                busy_rs2 = busy[i] & ~(gpr_we & (rd == rs2) & ~(mark_valid & (mark_rd == rs2)));
            end
        end
        if (gpr_we && rd == rs1) rsa = wd;
        if (gpr_we && rd == rs2) rsb = wd;
        for (int i = 0; i < NCSR; i++)
            if (int'(csr_rs) == i) csra = csr[i];
        if (csr_we && csr_rd == csr_rs) csra = csr_wd;
    end
endmodule

// File: tb/tb_wbu_param.sv
// Directed self-checking bench for wbu_param (NREG=16 instance) with
// hand-computed expectations.
module tb_wbu_param;
    localparam int XLEN = 32;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [4:0]      rd, rs1, rs2, mark_rd;
    logic            reg_en, csreg_en, ecall, ebreak_i, mark_valid;
    logic [XLEN-1:0] wd, csr_wd, pc_i, rsa, rsb, csra;
    logic [CW-1:0]   csr_rd, csr_rs;
    logic            busy_rs1, busy_rs2, ebreak_o;
    logic [63:0]     retire_cnt;
    logic [2:0]      state_o;

    int n_checks = 0;
    int n_errors = 0;

    wbu_param #(.XLEN(XLEN), .NREG(16), .NCSR(4), .CW(CW), .ARG_REG(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rd(rd), .reg_en(reg_en), .wd(wd), .csr_rd(csr_rd), .csreg_en(csreg_en),
        .csr_wd(csr_wd), .ecall(ecall), .ebreak_i(ebreak_i), .pc_i(pc_i),
        .rs1(rs1), .rs2(rs2), .csr_rs(csr_rs), .rsa(rsa), .rsb(rsb), .csra(csra),
        .mark_valid(mark_valid), .mark_rd(mark_rd), .busy_rs1(busy_rs1),
        .busy_rs2(busy_rs2), .ebreak_o(ebreak_o), .retire_cnt(retire_cnt),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; reg_en = 0; csreg_en = 0; ecall = 0; ebreak_i = 0; mark_valid = 0;
    endtask

    initial begin
        rst = 0; idle();
        rd = 0; wd = 0; csr_rd = 0; csr_wd = 0; pc_i = 0;
        rs1 = 0; rs2 = 0; csr_rs = 0; mark_rd = 0;
        tick(); tick();
        rs1 = 5; csr_rs = 2; #1;
        check("reset_rsa", rsa, 0);
        check("reset_cnt", retire_cnt, 0);
        check("reset_ready", in_ready, 1);
        check("reset_ebreak", ebreak_o, 0);
        check("reset_state_o", state_o, 0);
        check("reset_mstatus", csra, 0);
        rst = 1;

        // write x5 with same-cycle bypass
        in_valid = 1; reg_en = 1; rd = 5; wd = 32'hDEADBEEF; rs1 = 5; #1;
        check("bypass_rsa", rsa, 32'hDEADBEEF);
        check("state_o_gpr", state_o, 3'b011);
        tick(); idle(); #1;
        check("array_rsa", rsa, 32'hDEADBEEF);
        check("cnt_1", retire_cnt, 1);
        check("state_o_idle", state_o, 0);

        // x0 write ignored
        in_valid = 1; reg_en = 1; rd = 0; wd = 32'h1234; rs1 = 0; #1;
        check("x0_bypass", rsa, 0);
        tick(); idle(); #1;
        check("x0_array", rsa, 0);

        // out-of-range write dropped
        in_valid = 1; reg_en = 1; rd = 20; wd = 32'h55; tick(); idle();
        rs1 = 20; rs2 = 20; #1;
        check("oob_rsa", rsa, 0);
        check("oob_rsb", rsb, 0);
        check("cnt_3", retire_cnt, 3);

        // x15 = 0x0B and mstatus = 0x8 in one instruction
        in_valid = 1; reg_en = 1; rd = 15; wd = 32'h0B;
        csreg_en = 1; csr_rd = 2; csr_wd = 32'h8; csr_rs = 2; #1;
        check("state_o_both", state_o, 3'b111);
        check("csr_bypass", csra, 32'h8);
        tick(); idle(); rs2 = 15; #1;
        check("x15", rsb, 32'h0B);
        check("mstatus_8", csra, 32'h8);

        // ecall: trap cycle blocks input and does not retire
        in_valid = 1; ecall = 1; pc_i = 32'h80000010; #1;
        check("ready_pre_ecall", in_ready, 1);
        tick(); idle(); in_valid = 1; csr_rs = 0; #1;
        check("trap_ready", in_ready, 0);
        check("trap_state_o", state_o, 0);
        check("mcause", csra, 32'h0B);
        csr_rs = 1; #1;
        check("mepc", csra, 32'h80000010);
        tick(); in_valid = 0; csr_rs = 2; #1;
        check("post_trap_ready", in_ready, 1);
        check("mstatus_80", csra, 32'h80);
        check("cnt_5", retire_cnt, 5);

        // scoreboard
        mark_valid = 1; mark_rd = 7; rs1 = 7; rs2 = 0; #1;
        check("busy_not_yet", busy_rs1, 0);
        tick(); mark_valid = 0; #1;
        check("busy_set", busy_rs1, 1);
        check("busy_x0", busy_rs2, 0);
        in_valid = 1; reg_en = 1; rd = 7; wd = 32'h77; #1;
        check("busy_clr_same", busy_rs1, 0);
        tick(); idle(); #1;
        check("busy_clr_next", busy_rs1, 0);
        mark_valid = 1; mark_rd = 7; tick();
        in_valid = 1; reg_en = 1; rd = 7; wd = 32'h78; #1;
        check("busy_setwin_same", busy_rs1, 1);
        tick(); idle(); #1;
        check("busy_setwin_next", busy_rs1, 1);
        check("cnt_7", retire_cnt, 7);

        // ebreak halts; later input ignored
        in_valid = 1; ebreak_i = 1; tick();
        idle(); in_valid = 1; reg_en = 1; rd = 3; wd = 32'h99; rs1 = 3; #1;
        check("halt_ebreak", ebreak_o, 1);
        check("halt_ready", in_ready, 0);
        check("halt_state_o", state_o, 0);
        tick(); tick();
        check("halt_cnt", retire_cnt, 8);
        check("halt_no_write", rsa, 0);

        // reset out of HALT
        idle(); rst = 0; tick(); rst = 1; rs1 = 5; rs2 = 15; csr_rs = 2; #1;
        check("rst_ebreak", ebreak_o, 0);
        check("rst_ready", in_ready, 1);
        check("rst_cnt", retire_cnt, 0);
        check("rst_x5", rsa, 0);
        check("rst_x15", rsb, 0);
        check("rst_mstatus", csra, 0);
        rs1 = 7; #1;
        check("rst_busy", busy_rs1, 0);

        // retire counter wrap
        force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt;
        in_valid = 1; tick(); idle(); #1;
        check("cnt_wrap", retire_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
